// File: rtl/mem_arb_pkg.sv
// Shared state encoding and constants for mem_access_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned STATS_CNT_W = 16;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned WAIT_CNT_W  = $clog2(MEM_LAT_MAX);

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-side signals of mem_access_arbiter.
// master = arbiter view, slave = requesters plus memory array view.
interface mem_access_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 24
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  logic                      mem_cs;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  always_comb begin
    int unsigned cand;
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port word memory among NUM_REQ requesters.
// Optional per-requester grant counters when MEM_ARB_STATS_EN is defined.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                             stats_clr,
  output logic [NUM_REQ*STATS_CNT_W-1:0]   grant_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_access_arbiter: MEM_LAT out of range");
  end
  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num
    $error("mem_access_arbiter: NUM_REQ out of range");
  end

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      owner_q;
  logic                  write_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  mem_cs_q;
  logic                  mem_we_q;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  pick_write;
  logic [ADDR_W-1:0]     pick_addr;
  logic [DATA_W-1:0]     pick_wdata;
  logic [IDX_W-1:0]      rr_ptr_next;

  logic [NUM_REQ-1:0]    req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_d;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign pick_write  = bus.req_write[pick_idx];
  assign pick_addr   = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign pick_wdata  = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
  assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is gated by rst_n so a requester holding valid through reset sees 0
  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    if (state_q == IDLE && rst_n) req_ready_d = pick_gnt;
    if (state_q == RESP) rsp_valid_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q  <= pick_idx;
            write_q  <= pick_write;
            addr_q   <= pick_addr;
            wdata_q  <= pick_wdata;
            rr_ptr_q <= rr_ptr_next;
            mem_cs_q <= 1'b1;
            mem_we_q <= pick_write;
          end
        end
        ISSUE: wait_cnt_q <= WAIT_CNT_W'(MEM_LAT - 1);
        WAIT: begin
          if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
          else                  rdata_q    <= write_q ? '0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
    a_valid_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (bus.req_valid[g] && !bus.req_ready[g]) |=> bus.req_valid[g]
    );
  end

`ifdef MEM_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];

  // clear takes priority over a same-cycle grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_ready_d[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + STATS_CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*STATS_CNT_W +: STATS_CNT_W] = cnt_q[g];
  end
`endif

endmodule
